// File: rtl/latch_bank_pkg.sv
// Shared encodings for the latch_bank channel register bank.
package latch_bank_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD        = 2'b00,
        MODE_TRANSPARENT = 2'b01,
        MODE_CAPTURE     = 2'b10,
        MODE_TOGGLE      = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

endpackage

// File: rtl/latch_bank_cell.sv
// One WIDTH-bit channel word of the bank, updated only while selected.
module latch_cell
    import latch_bank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic [1:0]       mode,
    input  logic             strobe,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] lat_d, lat_q;

    always_comb begin
        lat_d = lat_q;
        if (sel) begin
            case (mode_e'(mode))
                MODE_TRANSPARENT: lat_d = din;
                MODE_CAPTURE:     if (strobe) lat_d = din;
                MODE_TOGGLE:      if (strobe) lat_d = lat_q ^ din;
                default:          lat_d = lat_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) lat_q <= '0;
        else     lat_q <= lat_d;
    end

    assign q = lat_q;

endmodule

// File: rtl/latch_bank.sv
// Multi-channel latch bank with registered readout and a full-bank scan sequencer.
module latch_bank
    import latch_bank_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CH_W     = $clog2(CHANNELS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [CH_W-1:0]  ch_sel,
    input  logic [WIDTH-1:0] din,
    input  logic             strobe,
    input  logic             invert,
    input  logic             scan_start,
    output logic [WIDTH-1:0] dout,
    output logic             scan_valid,
    output logic [CH_W-1:0]  scan_ch,
    output logic             busy
);

    logic [WIDTH-1:0] lat [CHANNELS];

    state_e           state_d, state_q;
    logic [CH_W-1:0]  cnt_d, cnt_q;
    logic [CH_W-1:0]  rd_idx;
    logic [WIDTH-1:0] rd_src;
    logic [WIDTH-1:0] dout_d, dout_q;
    logic             scan_valid_d, scan_valid_q;
    logic [CH_W-1:0]  scan_ch_d, scan_ch_q;
    logic             busy_d, busy_q;

    // Out-of-range selects match no cell, so writes to them are dropped.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        latch_cell #(.WIDTH(WIDTH)) u_cell (
            .clk    (clk),
            .rst    (rst),
            .sel    (32'(ch_sel) == c),
            .mode   (mode),
            .strobe (strobe),
            .din    (din),
            .q      (lat[c])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (scan_start) begin
                    state_d = ST_SCAN;
                    cnt_d   = '0;
                end
            end
            ST_SCAN: begin
                if (cnt_q == CH_W'(CHANNELS - 1)) state_d = ST_IDLE;
                else                              cnt_d   = cnt_q + CH_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read mux sees pre-update cell values, so a same-edge write shows next cycle.
    always_comb begin
        rd_idx = (state_q == ST_SCAN) ? cnt_q : ch_sel;
        rd_src = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (32'(rd_idx) == c) rd_src = lat[c];
        end
        dout_d       = invert ? ~rd_src : rd_src;
        scan_valid_d = (state_q == ST_SCAN);
        scan_ch_d    = scan_valid_d ? cnt_q : '0;
        busy_d       = scan_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            dout_q       <= '0;
            scan_valid_q <= 1'b0;
            scan_ch_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            scan_valid_q <= scan_valid_d;
            scan_ch_q    <= scan_ch_d;
            busy_q       <= busy_d;
        end
    end

    assign dout       = dout_q;
    assign scan_valid = scan_valid_q;
    assign scan_ch    = scan_ch_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_latch_bank.sv
// Drives a 4-channel and a 3-channel latch_bank with shared stimulus against a reference model.
module tb_latch_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode = 2'b00;
    logic [1:0] ch_sel = 2'd0;
    logic [7:0] din = 8'h00;
    logic       strobe = 1'b0;
    logic       invert = 1'b0;
    logic       scan_start = 1'b0;

    logic [7:0] dout4, dout3;
    logic       sv4, sv3, busy4, busy3;
    logic [1:0] sch4, sch3;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    latch_bank #(.WIDTH(8), .CHANNELS(4)) dut4 (
        .clk(clk), .rst(rst), .mode(mode), .ch_sel(ch_sel), .din(din),
        .strobe(strobe), .invert(invert), .scan_start(scan_start),
        .dout(dout4), .scan_valid(sv4), .scan_ch(sch4), .busy(busy4)
    );

    latch_bank #(.WIDTH(8), .CHANNELS(3)) dut3 (
        .clk(clk), .rst(rst), .mode(mode), .ch_sel(ch_sel), .din(din),
        .strobe(strobe), .invert(invert), .scan_start(scan_start),
        .dout(dout3), .scan_valid(sv3), .scan_ch(sch3), .busy(busy3)
    );

    // Reference model: m=0 is the 4-channel bank, m=1 the 3-channel bank.
    logic [7:0] mlat [2][4];
    int         nch [2] = '{4, 3};
    int         scan_list [2][$];
    logic [7:0] e_dout [2];
    logic       e_valid [2];
    int         e_ch [2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_edge(int m);
        logic [7:0] src;
        int sel;
        sel = int'(ch_sel);
        if (rst) begin
            for (int c = 0; c < 4; c++) mlat[m][c] = 8'h00;
            scan_list[m].delete();
            e_dout[m]  = 8'h00;
            e_valid[m] = 1'b0;
            e_ch[m]    = 0;
            return;
        end
        if (scan_list[m].size() > 0) begin
            e_ch[m]    = scan_list[m].pop_front();
            e_valid[m] = 1'b1;
            src        = mlat[m][e_ch[m]];
        end else begin
            e_ch[m]    = 0;
            e_valid[m] = 1'b0;
            src        = (sel < nch[m]) ? mlat[m][sel] : 8'h00;
            if (scan_start) for (int c = 0; c < nch[m]; c++) scan_list[m].push_back(c);
        end
        e_dout[m] = invert ? ~src : src;
        if (sel < nch[m]) begin
            case (mode)
                2'b01: mlat[m][sel] = din;
                2'b10: if (strobe) mlat[m][sel] = din;
                2'b11: if (strobe) mlat[m][sel] = mlat[m][sel] ^ din;
                default: ;
            endcase
        end
    endfunction

    // Inputs change at negedge; model advances at posedge; outputs compared 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check_val("dout4", 32'(dout4), 32'(e_dout[0]));
        check_val("valid4", 32'(sv4), 32'(e_valid[0]));
        check_val("busy4", 32'(busy4), 32'(e_valid[0]));
        check_val("scan_ch4", 32'(sch4), 32'(e_ch[0]));
        check_val("dout3", 32'(dout3), 32'(e_dout[1]));
        check_val("valid3", 32'(sv3), 32'(e_valid[1]));
        check_val("busy3", 32'(busy3), 32'(e_valid[1]));
        check_val("scan_ch3", 32'(sch3), 32'(e_ch[1]));
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] md, input logic [1:0] ch, input logic [7:0] d, input logic stb);
        mode = md; ch_sel = ch; din = d; strobe = stb;
        cyc();
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < 4; c++) mlat[m][c] = 8'h00;
            e_dout[m] = 8'h00; e_valid[m] = 1'b0; e_ch[m] = 0;
        end
        @(negedge clk);

        // Reset with invert high: 0 during reset, then all-ones.
        rst = 1'b1; invert = 1'b1;
        cyc(); cyc();
        check_val("rst_dout", 32'(dout4), 32'h00);
        check_val("rst_busy", 32'(busy4), 32'h0);
        rst = 1'b0;
        cyc();
        check_val("inv_after_rst", 32'(dout4), 32'hFF);
        invert = 1'b0;

        // Strobed capture into channel 2.
        wr(2'b10, 2'd2, 8'hA5, 1'b1);
        wr(2'b10, 2'd2, 8'h00, 1'b0);
        check_val("capture", 32'(dout4), 32'hA5);
        wr(2'b10, 2'd2, 8'h00, 1'b0);
        check_val("capture_hold", 32'(dout4), 32'hA5);
        wr(2'b00, 2'd0, 8'h00, 1'b0);
        check_val("ch0_untouched", 32'(dout4), 32'h00);

        // Toggle channel 1, then transparent stream.
        wr(2'b10, 2'd1, 8'h0F, 1'b1);
        wr(2'b11, 2'd1, 8'hFF, 1'b1);
        wr(2'b11, 2'd1, 8'hFF, 1'b0);
        check_val("toggle", 32'(dout4), 32'hF0);
        wr(2'b11, 2'd1, 8'hFF, 1'b0);
        check_val("toggle_nostb", 32'(dout4), 32'hF0);
        wr(2'b01, 2'd1, 8'h11, 1'b0);
        wr(2'b01, 2'd1, 8'h22, 1'b0);
        check_val("transp_11", 32'(dout4), 32'h11);
        wr(2'b00, 2'd1, 8'h00, 1'b0);
        check_val("transp_22", 32'(dout4), 32'h22);

        // Full scan, with an ignored scan_start and a write to the channel being scanned.
        for (int c = 0; c < 4; c++) wr(2'b01, 2'(c), 8'(16 * (c + 1)), 1'b0);
        mode = 2'b00; ch_sel = 2'd0;
        scan_start = 1'b1; cyc();
        scan_start = 1'b0; cyc();
        check_val("scan_first", 32'(dout4), 32'h10);
        scan_start = 1'b1; cyc();
        scan_start = 1'b0;
        mode = 2'b01; ch_sel = 2'd2; din = 8'h99;
        cyc();
        check_val("scan_old_val", 32'(dout4), 32'h30);
        mode = 2'b00;
        cyc(); cyc(); cyc();
        check_val("scan_done_busy", 32'(busy4), 32'h0);

        // Back-to-back scans with scan_start held high.
        scan_start = 1'b1;
        for (int i = 0; i < 12; i++) cyc();
        scan_start = 1'b0;
        for (int i = 0; i < 6; i++) cyc();

        // Reset in the middle of a scan.
        scan_start = 1'b1; cyc();
        scan_start = 1'b0; cyc(); cyc();
        check_val("mid_scan_ch", 32'(sch4), 32'h1);
        rst = 1'b1; cyc();
        check_val("rst_mid_valid", 32'(sv4), 32'h0);
        check_val("rst_mid_dout", 32'(dout4), 32'h00);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) wr(2'b00, 2'(c), 8'h00, 1'b0);
        cyc();

        // Out-of-range select on the 3-channel bank.
        wr(2'b01, 2'd3, 8'h55, 1'b0);
        wr(2'b00, 2'd3, 8'h00, 1'b0);
        check_val("oor_dout3", 32'(dout3), 32'h00);
        check_val("inrange_dout4", 32'(dout4), 32'h55);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            mode       = 2'($urandom_range(0, 3));
            ch_sel     = 2'($urandom_range(0, 3));
            din        = 8'($urandom);
            strobe     = 1'($urandom);
            invert     = ($urandom_range(0, 3) == 0);
            scan_start = ($urandom_range(0, 7) == 0);
            rst        = ($urandom_range(0, 63) == 0);
            cyc();
        end
        rst = 1'b0; scan_start = 1'b0;
        for (int i = 0; i < 6; i++) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/latch_bank.md
# latch_bank

Parametrised multi-channel latch/register bank, successor to the single-bit inverter/latch cell. It holds CHANNELS words of WIDTH bits, each updatable in hold, transparent, strobed-capture or toggle mode, with optional output inversion. A scan sequencer streams every channel out on consecutive cycles for readback through the tile's dedicated outputs.

## Interface

- WIDTH, 8, bits per channel (≥1)
- CHANNELS, 4, number of channel words (≥2)
- CH_W, $clog2(CHANNELS), channel index width (derived)

- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- mode  in  2  00 HOLD, 01 TRANSPARENT, 10 CAPTURE, 11 TOGGLE
- ch_sel  in  CH_W  channel addressed for write and normal readout
- din  in  WIDTH  write data
- strobe  in  1  qualifies CAPTURE/TOGGLE updates
- invert  in  1  dout = bitwise NOT of channel value when 1
- scan_start  in  1  request full-bank scan (sampled in IDLE only)
- dout  out  WIDTH  registered channel value
- scan_valid  out  1  dout carries a scanned channel this cycle
- scan_ch  out  CH_W  channel index of current scanned word
- busy  out  1  scan in progress

## Operation

- Per-channel register lat[c], reset to 0.
- Update of lat[ch_sel] each edge: HOLD none; TRANSPARENT lat<=din unconditionally; CAPTURE lat<=din iff strobe; TOGGLE lat<=lat^din iff strobe. Unselected channels never change.
- ch_sel ≥ CHANNELS: write ignored; normal readout gives 0 (before inversion).
- FSM states IDLE, SCAN. IDLE→SCAN on scan_start=1 (counter<=0). SCAN: counter increments each cycle; at counter=CHANNELS-1 → IDLE. scan_start ignored in SCAN.
- Read source: IDLE → lat[ch_sel]; SCAN → lat[counter]. dout <= invert ? ~src : src, using pre-update lat value of the same edge.
- Writes remain enabled during SCAN; a channel written at the same edge it is scanned shows its old value.
- invert applies in both states and takes effect on the next dout update.

## Timing

- Reset: dout=0, scan_valid=0, scan_ch=0, busy=0, all lat=0, state IDLE. dout=0 on the first post-reset cycle regardless of invert.
- All outputs registered; no combinational path input→output.
- Write at edge k → new value on dout from edge k+1 (when selected/scanned then).
- scan_start high at edge k: busy=1 and scan_valid=1 with scan_ch=0 from edge k+1; channel i presented after edge k+1+i; busy and scan_valid drop after edge k+CHANNELS+1. Exactly CHANNELS valid cycles, no gaps.
- Back-to-back: scan_start held high continuously re-triggers in the first IDLE cycle, giving one idle cycle between scans.
- rst mid-scan: next edge returns to reset state; scan aborted, no further valid words.
- scan_ch is 0 whenever scan_valid=0.

## Structure

- Package latch_bank_pkg: mode encodings (MODE_HOLD, MODE_TRANSPARENT, MODE_CAPTURE, MODE_TOGGLE), FSM state type (ST_IDLE, ST_SCAN).
- Sub-module latch_cell: one WIDTH-bit channel register with mode/strobe/select update logic and sync reset; instantiated CHANNELS times by generate.
- Top holds FSM, scan counter, read mux, inversion and output registers.

## Test plan

- Reset then idle: rst=1 two cycles, invert=1 → dout=0 first cycle, 0xFF following (WIDTH=8), busy=0.
- CAPTURE: ch_sel=2, din=0xA5, strobe=1 one cycle then strobe=0, din=0x00 → dout=0xA5 from next edge, held; other channels remain 0.
- TOGGLE: ch1=0x0F, TOGGLE din=0xFF strobe=1 → 0xF0; strobe=0 → stays 0xF0; TRANSPARENT din stream 0x11,0x22 → dout follows one cycle late.
- Scan: ch0..3 = 0x10,0x20,0x30,0x40, scan_start pulse → four scan_valid cycles, scan_ch 0..3, dout 0x10..0x40, then busy=0; scan_start during scan ignored.
- Reset mid-scan: assert rst at scan_ch=1 → next cycle scan_valid=0, busy=0, dout=0, all channels cleared.
- Out-of-range select (CHANNELS=3, ch_sel=3): write 0x55 ignored, dout=0; simultaneous write to scanned channel returns old value that cycle.
